// File: rtl/mem_responder.sv
// mem_responder: responder end of a valid/ready memory-request channel.
// It owns a word-addressed synchronous RAM and a 2-entry in-order response queue.
// req_ready depends only on registered queue occupancy, so response backpressure
// never reaches it combinationally.
module mem_responder #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic                    req_write,
   input  logic [WIDTH-1:0]        req_wdata,
   input  logic [WIDTH/8-1:0]      req_wstrb,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [WIDTH-1:0]        resp_data,
   output logic                    resp_write
);

   localparam int NBYTES = WIDTH / 8;
   localparam int DEPTH  = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic              r_head;
   logic              r_tail;
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [WIDTH-1:0]  r_q_data [2];
   logic [1:0]        r_q_write;

   logic              w_accept;
   logic              w_pop;
   logic [WIDTH-1:0]  w_old_word;
   logic [WIDTH-1:0]  w_merged;

   // A request held during reset is never taken, so the RAM cannot change while in reset.
   assign w_accept   = req_valid && req_ready && reset;
   assign w_pop      = resp_valid && resp_ready;
   assign w_old_word = r_mem[req_addr];

   // Build the written word byte by byte: enabled bytes come from req_wdata, the rest are kept.
   for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign w_merged[8*gi +: 8] = req_wstrb[gi] ? req_wdata[8*gi +: 8] : w_old_word[8*gi +: 8];
   end

   // Queue occupancy state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next occupancy: accept adds an entry, pop removes one, and both together leave it unchanged.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_EMPTY: if (w_accept) w_state_next = S_ONE;
         S_ONE: begin
            if (w_accept && !w_pop)      w_state_next = S_FULL;
            else if (w_pop && !w_accept) w_state_next = S_EMPTY;
         end
         S_FULL:  if (w_pop) w_state_next = S_ONE;
         default: w_state_next = S_EMPTY;
      endcase
   end

   // Channel outputs come from registered state and the queue head. Data reads as zero when empty.
   always_comb begin
      req_ready  = (r_state != S_FULL);
      resp_valid = (r_state != S_EMPTY);
      resp_data  = resp_valid ? r_q_data[r_head] : '0;
      resp_write = resp_valid & r_q_write[r_head];
   end

   // Head and tail pointers are one bit each, so they wrap modulo 2.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_head <= 1'b0;
         r_tail <= 1'b0;
      end else begin
         if (w_accept) r_tail <= ~r_tail;
         if (w_pop)    r_head <= ~r_head;
      end
   end

   // Push on accept: the queue entry captures the pre-write RAM word (read-first).
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q_data[0] <= '0;
         r_q_data[1] <= '0;
         r_q_write   <= '0;
      end else if (w_accept) begin
         r_q_data[r_tail]  <= w_old_word;
         r_q_write[r_tail] <= req_write;
      end
   end

   // RAM write port. The RAM has no reset, so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (w_accept && req_write) begin
         r_mem[req_addr] <= w_merged;
      end
   end

endmodule
